// File: rtl/gsram_sweep_sched_pkg.sv
// Shared constants for the gSRAM sweep scheduler: FSM state codes, requester
// indices and default array geometry.
package gsram_sweep_sched_pkg;

   localparam int ROWS_DEF = 10;
   localparam int COLS_DEF = 10;
   localparam int AW_DEF   = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WR    = 3'd1;
   localparam logic [2:0] ST_RD    = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [1:0] REQ_M2  = 2'd0;
   localparam logic [1:0] REQ_LUT = 2'd1;
   localparam logic [1:0] REQ_RD  = 2'd2;

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b010:  idx = REQ_LUT;
         3'b100:  idx = REQ_RD;
         default: idx = REQ_M2;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/gsram_sweep_sched_rr_arb3.sv
// Three-way round-robin arbiter; priority starts just after the last served
// requester, which is recorded only on the advance strobe.
module gsram_sweep_sched_rr_arb3
   import gsram_sweep_sched_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_req,
   input  logic       i_advance,
   input  logic [1:0] i_served,
   output logic [2:0] o_gnt
);

   logic [1:0] r_last;
   logic [2:0] w_gnt;

   // Rotating-priority pick of one requester
   always_comb begin
      w_gnt = 3'b000;
      case (r_last)
         REQ_M2: begin
            if      (i_req[1]) w_gnt = 3'b010;
            else if (i_req[2]) w_gnt = 3'b100;
            else if (i_req[0]) w_gnt = 3'b001;
            else               w_gnt = 3'b000;
         end
         REQ_LUT: begin
            if      (i_req[2]) w_gnt = 3'b100;
            else if (i_req[0]) w_gnt = 3'b001;
            else if (i_req[1]) w_gnt = 3'b010;
            else               w_gnt = 3'b000;
         end
         default: begin
            if      (i_req[0]) w_gnt = 3'b001;
            else if (i_req[1]) w_gnt = 3'b010;
            else if (i_req[2]) w_gnt = 3'b100;
            else               w_gnt = 3'b000;
         end
      endcase
   end

   // Last-served pointer; reset value makes M2 the highest priority
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= REQ_RD;
      end else if (i_advance) begin
         r_last <= i_served;
      end else begin
         r_last <= r_last;
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/gsram_sweep_sched.sv
// gSRAM sweep scheduler: grants one of M2 writer, LUT writer or read-out a full
// row-major sweep of the array and drives we/row/col/inmuxsel plus read tags.
module gsram_sweep_sched
   import gsram_sweep_sched_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int AW   = AW_DEF
)(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [2:0]    i_req,
   output logic [2:0]    o_gnt,
   output logic          o_sweep_done,
   input  logic [1:0]    i_src_valid,
   output logic [1:0]    o_src_ready,
   output logic          o_we,
   output logic [AW-1:0] o_row,
   output logic [AW-1:0] o_col,
   output logic          o_inmuxsel,
   output logic          o_rd_valid,
   output logic [AW-1:0] o_rd_row,
   output logic [AW-1:0] o_rd_col
);

   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
   localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);
   localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
   localparam logic [AW-1:0] ONE      = AW'(1'b1);

   logic [2:0]    r_state;
   logic [2:0]    r_gnt;
   logic [AW-1:0] r_row;
   logic [AW-1:0] r_col;
   logic          r_inmux;
   logic          r_done;
   logic          r_rd_valid;
   logic [AW-1:0] r_rd_row;
   logic [AW-1:0] r_rd_col;

   logic [2:0]    w_arb_gnt;
   logic          w_sel_valid;
   logic          w_last;
   logic [AW-1:0] w_row_nxt;
   logic [AW-1:0] w_col_nxt;

   gsram_sweep_sched_rr_arb3 u_arb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (i_req),
      .i_advance (r_state == ST_DONE),
      .i_served  (onehot_to_idx(r_gnt)),
      .o_gnt     (w_arb_gnt)
   );

   // Row-major address advance and end-of-sweep detect
   always_comb begin
      w_sel_valid = r_inmux ? i_src_valid[1] : i_src_valid[0];
      w_last      = (r_row == LAST_ROW) && (r_col == LAST_COL);
      if (r_col == LAST_COL) begin
         w_col_nxt = ZERO;
         w_row_nxt = r_row + ONE;
      end else begin
         w_col_nxt = r_col + ONE;
         w_row_nxt = r_row;
      end
   end

   assign o_we        = (r_state == ST_WR) & w_sel_valid;
   assign o_src_ready = (r_state == ST_WR) ? (r_inmux ? 2'b10 : 2'b01) : 2'b00;

   // Sweep FSM; read tags trail the issued address by one edge to match gSRAM rdata
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_gnt      <= 3'b000;
         r_row      <= ZERO;
         r_col      <= ZERO;
         r_inmux    <= 1'b0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_row   <= ZERO;
         r_rd_col   <= ZERO;
      end else begin
         r_rd_valid <= (r_state == ST_RD);
         if (r_state == ST_RD) begin
            r_rd_row <= r_row;
            r_rd_col <= r_col;
         end
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req != 3'b000) begin
                  r_gnt   <= w_arb_gnt;
                  r_row   <= ZERO;
                  r_col   <= ZERO;
                  r_inmux <= w_arb_gnt[REQ_LUT];
                  r_state <= w_arb_gnt[REQ_RD] ? ST_RD : ST_WR;
               end
            end
            ST_WR: begin
               if (o_we) begin
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_row <= w_row_nxt;
                     r_col <= w_col_nxt;
                  end
               end
            end
            ST_RD: begin
               if (w_last) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_row <= w_row_nxt;
                  r_col <= w_col_nxt;
               end
            end
            ST_DRAIN: begin
               r_state <= ST_DONE;
               r_done  <= 1'b1;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_gnt   <= 3'b000;
               r_row   <= ZERO;
               r_col   <= ZERO;
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= 3'b000;
            end
         endcase
      end
   end

   assign o_gnt        = r_gnt;
   assign o_sweep_done = r_done;
   assign o_row        = r_row;
   assign o_col        = r_col;
   assign o_inmuxsel   = r_inmux;
   assign o_rd_valid   = r_rd_valid;
   assign o_rd_row     = r_rd_row;
   assign o_rd_col     = r_rd_col;

endmodule
